// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces the
// lowest active column, and shifts each accepted key code into a 4-digit
// hex entry register.
module keypad_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  col_i,
  input  logic        clr_i,
  output logic [3:0]  row_o,
  output logic [3:0]  key_o,
  output logic        key_valid_o,
  output logic        key_down_o,
  output logic [15:0] data_o
);

  localparam int                CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  DIV_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_MAX = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HOLD,
    S_RELEASE
  } state_e;

  state_e           state_q;
  logic [3:0]       col_s1_q, col_s2_q;
  logic             run_q;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick;
  logic [3:0]       row_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       deb_q;
  logic [3:0]       deb_inc;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_down_q;
  logic [15:0]      data_q;
  logic             any_low;
  logic [1:0]       low_idx;
  logic [3:0]       new_key;

  // Two-flop synchronizer for the asynchronous, active-low column lines.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_i;
      col_s2_q <= col_s1_q;
    end
  end

  // Reset-release synchronizer: the prescaler starts one edge after rst rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Prescaler next count, wrapping at SCAN_DIV-1.
  always_comb begin
    div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
  end

  // Prescaler counter, frozen until the reset release has been synchronized.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    div_q <= '0;
    else if (run_q) div_q <= div_d;
  end

  assign tick = run_q && (div_q == DIV_MAX);

  // Lowest-numbered low column wins; saturating debounce increment.
  always_comb begin
    any_low = ~&col_s2_q;
    casez (col_s2_q)
      4'b???0: low_idx = 2'd0;
      4'b??01: low_idx = 2'd1;
      4'b?011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
    deb_inc = (deb_q >= DEB_MAX) ? DEB_MAX : deb_q + 4'd1;
    new_key = {row_idx_q, col_idx_q};
  end

  // Scan/debounce/hold/release FSM with registered outputs and entry register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_SCAN;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      deb_q       <= 4'd0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      data_q      <= 16'h0000;
    end else begin
      key_valid_q <= 1'b0;
      if (clr_i) data_q <= 16'h0000;
      if (tick) begin
        unique case (state_q)
          S_SCAN: begin
            if (!any_low) begin
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
            end else begin
              col_idx_q <= low_idx;
              deb_q     <= 4'd0;
              state_q   <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (any_low && (low_idx == col_idx_q)) begin
              if (deb_inc == DEB_MAX) begin
                key_q       <= new_key;
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                // A coincident clear wins over the old digits but keeps the new key.
                data_q      <= clr_i ? {12'h000, new_key} : {data_q[11:0], new_key};
                deb_q       <= 4'd0;
                state_q     <= S_HOLD;
              end else begin
                deb_q <= deb_inc;
              end
            end else begin
              // Bounce or a different column: retry on the same row.
              deb_q   <= 4'd0;
              state_q <= S_SCAN;
            end
          end
          S_HOLD: begin
            if (!any_low) begin
              deb_q   <= 4'd0;
              state_q <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (any_low) begin
              deb_q   <= 4'd0;
              state_q <= S_HOLD;
            end else if (deb_inc == DEB_MAX) begin
              deb_q      <= 4'd0;
              key_down_q <= 1'b0;
              row_q      <= {row_q[2:0], row_q[3]};
              row_idx_q  <= row_idx_q + 2'd1;
              state_q    <= S_SCAN;
            end else begin
              deb_q <= deb_inc;
            end
          end
          default: state_q <= S_SCAN;
        endcase
      end
    end
  end

  assign row_o       = row_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign key_down_o  = key_down_q;
  assign data_o      = data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a combinational 4x4 keypad model closes row/column
// contacts, a queue holds expected {key, data} per press, and each scenario
// task compares the DUT against it.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key;
  logic        kv;
  logic        kd;
  logic [15:0] data;
  logic [15:0] pressed = 16'h0000;

  int          n_vec = 0;
  int          n_err = 0;
  logic [19:0] sb[$];
  logic [15:0] exp_data = 16'h0000;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .col_i       (col),
    .clr_i       (clr),
    .row_o       (row),
    .key_o       (key),
    .key_valid_o (kv),
    .key_down_o  (kd),
    .data_o      (data)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic push_key(input int r, input int c);
    logic [3:0] k;
    k = {2'(r), 2'(c)};
    exp_data = {exp_data[11:0], k};
    sb.push_back({k, exp_data});
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    logic [19:0] e;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (kv) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: key_valid got 0, required 1 within 60 clk", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s_unexpected: key_valid with key=%h, required none", name, key);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (key !== e[19:16]) begin n_err++; $display("FAIL %s_key: got %h, required %h", name, key, e[19:16]); end
      n_vec++;
      if (data !== e[15:0]) begin n_err++; $display("FAIL %s_data: got %h, required %h", name, data, e[15:0]); end
      n_vec++;
      if (kd !== 1'b1) begin n_err++; $display("FAIL %s_key_down: got %b, required 1", name, kd); end
      @(negedge clk);
      n_vec++;
      if (kv !== 1'b0) begin n_err++; $display("FAIL %s_pulse_width: key_valid got %b, required 0", name, kv); end
    end
  endtask

  task automatic release_keys(input logic [15:0] mask, input string name);
    bit done;
    int kvc;
    done = 1'b0;
    kvc = 0;
    pressed = pressed & ~mask;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (kv) kvc++;
      if (!kd) done = 1'b1;
    end
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL %s_release: key_down got %b, required 0 within 60 clk", name, kd); end
    n_vec++;
    if (kvc !== 0) begin n_err++; $display("FAIL %s_release_valid: %0d key_valid pulses, required 0", name, kvc); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    exp_data = 16'h0000;
    repeat (3) @(negedge clk);
    n_vec++; if (row  !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b, required 1110", row); end
    n_vec++; if (key  !== 4'h0)    begin n_err++; $display("FAIL reset_key: got %h, required 0", key); end
    n_vec++; if (kv   !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b, required 0", kv); end
    n_vec++; if (kd   !== 1'b0)    begin n_err++; $display("FAIL reset_down: got %b, required 0", kd); end
    n_vec++; if (data !== 16'h0)   begin n_err++; $display("FAIL reset_data: got %h, required 0000", data); end
  endtask

  task automatic test_idle_scan;
    logic [3:0] prev;
    int last, changes, kvc, exp_gap;
    prev = row; last = 0; changes = 0; kvc = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (kv) kvc++;
      if (row !== prev) begin
        changes++;
        exp_gap = (changes == 1) ? 5 : SCAN_DIV;
        n_vec++;
        if (row !== {prev[2:0], prev[3]}) begin n_err++; $display("FAIL idle_rotate: got %b, required %b", row, {prev[2:0], prev[3]}); end
        n_vec++;
        if ((i - last) !== exp_gap) begin n_err++; $display("FAIL idle_interval: got %0d clk, required %0d", i - last, exp_gap); end
        last = i;
        prev = row;
      end
    end
    n_vec++; if (changes !== 9) begin n_err++; $display("FAIL idle_changes: got %0d, required 9", changes); end
    n_vec++; if (kvc !== 0) begin n_err++; $display("FAIL idle_valid: got %0d pulses, required 0", kvc); end
  endtask

  task automatic test_single_key;
    int kvc, drop;
    kvc = 0; drop = 0;
    press(2, 1);
    push_key(2, 1);
    wait_valid("single");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (kv) kvc++;
      if (!kd) drop++;
    end
    n_vec++; if (kvc !== 0) begin n_err++; $display("FAIL single_extra_valid: got %0d, required 0", kvc); end
    n_vec++; if (drop !== 0) begin n_err++; $display("FAIL single_hold_down: low for %0d clk, required 0", drop); end
    n_vec++; if (data !== 16'h0009) begin n_err++; $display("FAIL single_data: got %h, required 0009", data); end
    release_keys(16'hFFFF, "single");
    n_vec++; if (key !== 4'h9) begin n_err++; $display("FAIL single_key_kept: got %h, required 9", key); end
  endtask

  task automatic enter_key(input int r, input int c, input string name);
    press(r, c);
    push_key(r, c);
    wait_valid(name);
    release_keys(16'hFFFF, name);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_sequence;
    enter_key(0, 1, "seq1");
    enter_key(0, 2, "seq2");
    enter_key(0, 3, "seq3");
    enter_key(1, 0, "seq4");
    enter_key(1, 1, "seq5");
    n_vec++; if (data !== 16'h2345) begin n_err++; $display("FAIL seq_data: got %h, required 2345", data); end
  endtask

  task automatic test_bounce;
    int kvc, kdc, changes, r;
    logic [3:0] prev;
    kvc = 0; kdc = 0; changes = 0;
    for (int rep = 0; rep < 6; rep++) begin
      r = 0;
      for (int j = 0; j < 4; j++) if (!row[j]) r = j;
      press(r, 1);
      repeat (SCAN_DIV) begin @(negedge clk); if (kv) kvc++; if (kd) kdc++; end
      pressed = 16'h0000;
      repeat (3 * SCAN_DIV) begin @(negedge clk); if (kv) kvc++; if (kd) kdc++; end
    end
    n_vec++; if (kvc !== 0) begin n_err++; $display("FAIL bounce_valid: got %0d pulses, required 0", kvc); end
    n_vec++; if (kdc !== 0) begin n_err++; $display("FAIL bounce_down: high for %0d clk, required 0", kdc); end
    prev = row;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
    end
    n_vec++; if (changes !== 8) begin n_err++; $display("FAIL bounce_resume: %0d row changes, required 8", changes); end
  endtask

  task automatic test_hold_other_rows;
    int kvc, drop;
    kvc = 0; drop = 0;
    press(2, 1);
    push_key(2, 1);
    wait_valid("hold9");
    press(0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kv) kvc++;
      if (!kd) drop++;
    end
    n_vec++; if (kvc !== 0) begin n_err++; $display("FAIL hold_other_valid: got %0d pulses, required 0", kvc); end
    n_vec++; if (drop !== 0) begin n_err++; $display("FAIL hold_other_down: low for %0d clk, required 0", drop); end
    release_keys(16'h0200, "hold9");
    push_key(0, 0);
    wait_valid("after_release");
    release_keys(16'hFFFF, "key0");
    repeat (8) @(negedge clk);
    press(1, 0);
    press(1, 2);
    push_key(1, 0);
    wait_valid("priority");
    release_keys(16'hFFFF, "priority");
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_data = 16'h0000;
    n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL clr_data: got %h, required 0000", data); end
    n_vec++; if (key !== 4'h4) begin n_err++; $display("FAIL clr_key: got %h, required 4", key); end
    n_vec++; if (kd !== 1'b0) begin n_err++; $display("FAIL clr_down: got %b, required 0", kd); end
  endtask

  task automatic test_clr_coincident;
    logic [3:0] prev;
    logic [19:0] e;
    bit found;
    enter_key(0, 1, "pre1");
    enter_key(0, 2, "pre2");
    enter_key(0, 3, "pre3");
    enter_key(1, 0, "pre4");
    n_vec++; if (data !== 16'h1234) begin n_err++; $display("FAIL clrc_pre_data: got %h, required 1234", data); end
    found = 1'b0;
    prev = row;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row === 4'b1011 && prev !== 4'b1011) found = 1'b1;
      prev = row;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL clrc_row_timeout: row got %b, required 1011 within 40 clk", row); end
    // Row 2 just became active on a tick: detect 1 tick later, accept DEBOUNCE ticks after that.
    press(2, 2);
    exp_data = 16'h000A;
    sb.push_back({4'hA, exp_data});
    repeat ((DEBOUNCE + 1) * SCAN_DIV - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    e = sb.pop_front();
    n_vec++; if (kv !== 1'b1) begin n_err++; $display("FAIL clrc_valid: got %b, required 1", kv); end
    n_vec++; if (key !== e[19:16]) begin n_err++; $display("FAIL clrc_key: got %h, required %h", key, e[19:16]); end
    n_vec++; if (data !== e[15:0]) begin n_err++; $display("FAIL clrc_data: got %h, required %h", data, e[15:0]); end
    @(negedge clk);
    n_vec++; if (kv !== 1'b0) begin n_err++; $display("FAIL clrc_pulse_width: got %b, required 0", kv); end
    release_keys(16'hFFFF, "clrc");
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold;
    press(2, 1);
    push_key(2, 1);
    wait_valid("pre_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (row  !== 4'b1110) begin n_err++; $display("FAIL rst_hold_row: got %b, required 1110", row); end
    n_vec++; if (key  !== 4'h0)    begin n_err++; $display("FAIL rst_hold_key: got %h, required 0", key); end
    n_vec++; if (kv   !== 1'b0)    begin n_err++; $display("FAIL rst_hold_valid: got %b, required 0", kv); end
    n_vec++; if (kd   !== 1'b0)    begin n_err++; $display("FAIL rst_hold_down: got %b, required 0", kd); end
    n_vec++; if (data !== 16'h0)   begin n_err++; $display("FAIL rst_hold_data: got %h, required 0000", data); end
    exp_data = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_key(2, 1);
    wait_valid("re_debounce");
    release_keys(16'hFFFF, "re_debounce");
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_sequence();
    test_bounce();
    test_hold_other_rows();
    test_clr();
    test_clr_coincident();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, giving the clk cycles per scan tick (1 kHz at 100 MHz); legal values are >= 4.
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the consecutive scan ticks needed to accept a press or a release; legal range is 1..15.
REQ-003 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 col  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of the entry register, active-high.
REQ-007 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 key  output  4  code of the last accepted key.
REQ-009 key_valid  output  1  one-clk pulse when a key is accepted.
REQ-010 key_down  output  1  high from acceptance until release is accepted.
REQ-011 data  output  16  entry register holding the last four hex digits, newest digit in [3:0].

Function
REQ-012 col SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-013 A prescaler SHALL assert an internal tick for one clk every SCAN_DIV clk cycles; column evaluation SHALL occur only on tick.
REQ-014 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-015 In SCAN, on tick with all columns high, row SHALL rotate 1110->1101->1011->0111->1110.
REQ-016 In SCAN, on tick with any column low, the FSM SHALL freeze row, latch the column index and enter DEBOUNCE.
REQ-017 The column index SHALL be that of the lowest-numbered low column (col[0] has the highest priority).
REQ-018 In DEBOUNCE, each tick where the same column index is still the lowest low column SHALL increment a debounce counter.
REQ-019 In DEBOUNCE, any tick with a different column index or with all columns high SHALL clear the counter and return to SCAN without rotating row that tick.
REQ-020 When the debounce counter reaches DEBOUNCE, the block SHALL accept the key: key = {row_index[1:0], col_index[1:0]} (row_index 0 corresponds to row=1110).
REQ-021 On acceptance, key_valid SHALL pulse for exactly one clk, data SHALL become {data[11:0], key}, key_down SHALL go high, and the FSM SHALL enter HOLD.
REQ-022 In HOLD, the first tick with all columns high SHALL enter RELEASE.
REQ-023 In RELEASE, DEBOUNCE consecutive all-high ticks SHALL drop key_down, rotate row and enter SCAN.
REQ-024 In RELEASE, any tick with a column low SHALL return to HOLD without a new key_valid.
REQ-025 Presses on other rows during HOLD or RELEASE SHALL be ignored, since row stays frozen.
REQ-026 Worst-case latency from a stable press to key_valid SHALL be (DEBOUNCE+4)*SCAN_DIV+3 clk cycles.
REQ-027 The latency from the accepting tick to key_valid SHALL be 1 clk.
REQ-028 clr SHALL set data to 0 on the next edge and SHALL NOT affect the FSM, key, key_down or row.
REQ-029 If clr and acceptance occur in the same cycle, data SHALL become {12'h000, key} and key_valid SHALL still pulse.
REQ-030 The debounce counter SHALL saturate at DEBOUNCE and never wrap.
REQ-031 The prescaler SHALL wrap from SCAN_DIV-1 to 0.

Reset
REQ-032 While rst is low, the block SHALL hold row=1110, key=0, key_valid=0, key_down=0, data=16'h0000, FSM=SCAN, and the prescaler, debounce counter and synchronizer at 0/all-high.
REQ-033 Asserting rst mid-press SHALL discard the press; after release of rst the key SHALL be re-debounced from SCAN.
REQ-034 Deassertion of rst SHALL be synchronized internally so the first prescaler count occurs on the second clk edge after rst rises.

Verification
REQ-035 SCAN_DIV=4, DEBOUNCE=2, no keys pressed -> row cycles 1110,1101,1011,0111 every 4 clk, key_valid never asserts.
REQ-036 Press row 2 / col 1 held stable -> exactly one key_valid, key=4'h9, data=16'h0009, key_down high until release is debounced.
REQ-037 Enter keys 1,2,3,4,5 in sequence -> data=16'h2345 after the fifth key_valid.
REQ-038 Bounce col low for 1 tick then high, repeated -> no key_valid, row resumes rotation.
REQ-039 Hold key 4'h9 and also press row 0 keys -> no second key_valid until after release; col[0] and col[2] low together on one row -> key reflects col 0.
REQ-040 clr coincident with acceptance of key 4'hA while data=16'h1234 -> data=16'h000A; rst low mid-HOLD -> all outputs return to REQ-032 values immediately.
